mgt_01_booth_multiplier: RTL and testbench
==========================================

# mgt_01_booth_multiplier

Parametrised, handshaked, iterative Booth radix-4 multiplier for the MicroGT-01 execute stage; next-generation replacement for the fixed 32-bit multiplication unit. Accepts one RV32M-style multiply (MUL/MULH/MULHSU/MULHU) at a time over a valid/ready interface and computes the product in (XLEN+2)/2 recode steps. Correct signed/unsigned semantics come from per-operation operand extension, not result post-correction. A zero-operand fast path, a kill/flush input and a pass-through tag for the issue logic are included.

## Interface
- XLEN, 32: operand/result width; even, >= 4.
- TAG_W, 4: width of the opaque tag carried with each operation.
- EARLY_ZERO, 1: 1 enables the zero-operand fast path.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clk_en_i  in  1  stall; low freezes all state, valid_o and ready_o hold.
- kill_i  in  1  flush of the in-flight operation.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i && ready_o && clk_en_i.
- operation_i  in  mul_ops_e  MUL_/MULH_/MULHSU_/MULHU_.
- operand_a_i  in  XLEN  rs1 (multiplicand).
- operand_b_i  in  XLEN  rs2 (multiplier, Booth-recoded).
- tag_i  in  TAG_W  request tag.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready; result retired when valid_o && ready_i && clk_en_i.
- result_o  out  XLEN  selected product half.
- tag_o  out  TAG_W  tag of the operation on result_o.
- fu_state_o  out  fu_state_e  FREE in IDLE, else BUSY.

## Operation
- States, mul_state_e: IDLE, COMPUTE, DONE. Reset: IDLE, ready_o=1, valid_o=0, result_o=0, tag_o=0, fu_state_o=FREE, all datapath registers 0.
- Extension to XLEN+2 bits on accept: a is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU. b is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
- Accept: load P=0, A=ext(b), L=0, B=ext(a), step counter=0, latch op and tag. Go to COMPUTE. With EARLY_ZERO=1 and a==0 or b==0, go straight to DONE with product 0.
- COMPUTE step: recode {A[1:0],L} to 0, +B, +2B, -2B, -B (111/000 give 0). P is XLEN+3 bits. Arithmetic-shift {P,A,L} right by 2. Counter increments; after step ITER=(XLEN+2)/2 go to DONE.
- Product is the low 2*XLEN bits of {P,A}. MUL returns the low XLEN bits; all MULH* return the high XLEN bits.
- ready_o = (state==IDLE) || (state==DONE && ready_i), and is forced 0 while kill_i=1. Accept in DONE with retire in the same cycle gives back-to-back operation.
- DONE: valid_o=1, result_o/tag_o stable until retire. On retire go to IDLE, or to COMPUTE/DONE if a new accept happens in the same cycle.
- kill_i (requires clk_en_i): any state goes to IDLE next edge. It has priority over accept and retire. The killed result is never presented; valid_o falls the next cycle.
- rst_i mid-operation: immediate return to reset values; no partial result appears.

## Timing
- Accept in cycle N: normal path valid_o is high from cycle N+ITER+1, which is N+18 for XLEN=32. Fast path valid_o is high from cycle N+1.
- Sustained throughput: one op per ITER+1 cycles with ready_i held high.
- Outputs are registered. ready_o is combinational from state, kill_i and ready_i.
- A cycle with clk_en_i low does not count toward latency.

## Structure
- Add mul_state_e and a localparam function for ITER to Primitives/Modules_pkg.svh. mul_ops_e and fu_state_e stay in the existing packages.
- One sub-module, mgt_01_booth_r4_step: combinational recode, add and 2-bit arithmetic shift, parametrised on XLEN.
- The top level holds the FSM, counter, operand extension, result select and handshake.

## Test plan
- XLEN=32, MUL a=7, b=-3 -> result_o=0xFFFFFFEB, valid_o first high exactly 18 cycles after accept.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- EARLY_ZERO=1, MULHU a=0, b=0x12345678 -> 0x00000000 one cycle after accept. With EARLY_ZERO=0 the same result takes 18 cycles.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> result_o/tag_o stable, ready_o=0. Then retire with a new valid_i in the same cycle -> back-to-back accept, correct second result.
- kill_i at step 8 with valid_i=1 -> request not accepted, IDLE next cycle, no valid_o. The next op computes correctly.
- rst_i asserted mid-COMPUTE and clk_en_i low for 3 cycles mid-op -> reset values immediately, and latency extended by exactly 3 cycles, respectively.

Source files
------------

// File: rtl/mgt_01_booth_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// mgt_01_booth_multiplier_pkg
// Shared types for the MicroGT-01 iterative Booth radix-4 multiplier:
//   mul_ops_e   - RV32M multiply flavour (low half, or high half with a
//                 given signedness of rs1/rs2)
//   fu_state_e  - functional-unit occupancy reported to the issue logic
//   mul_state_e - multiplier control FSM states
//   iter_f      - number of radix-4 recode steps for a given XLEN
// -----------------------------------------------------------------------------
package mgt_01_booth_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHSU_ = 2'd2,
        MULHU_  = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mul_state_e;

    // Operands are extended to XLEN+2 bits, and each radix-4 step retires
    // two multiplier bits.
    function automatic int iter_f(input int xlen);
        return (xlen + 2) / 2;
    endfunction

endpackage

// File: rtl/mgt_01_booth_r4_step.sv
// -----------------------------------------------------------------------------
// mgt_01_booth_r4_step
// One combinational radix-4 Booth step: recode {a_i[1:0], l_i}, add the
// selected multiple of the multiplicand to the partial product, then
// arithmetic-shift {P, A, L} right by two bits.
//   p_i/p_o  XLEN+3  partial product (signed)
//   a_i/a_o  XLEN+2  multiplier / low product bits
//   l_i/l_o  1       previous multiplier bit
//   b_i      XLEN+2  extended multiplicand (signed)
// -----------------------------------------------------------------------------
module mgt_01_booth_r4_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN+2:0] p_i,
    input  logic [XLEN+1:0] a_i,
    input  logic            l_i,
    input  logic [XLEN+1:0] b_i,
    output logic [XLEN+2:0] p_o,
    output logic [XLEN+1:0] a_o,
    output logic            l_o
);

    logic [XLEN+2:0] b_x1;
    logic [XLEN+2:0] b_x2;
    logic [XLEN+2:0] sum;

    // |B| <= 2^XLEN, so both multiples fit in XLEN+3 signed bits.
    assign b_x1 = {b_i[XLEN+1], b_i};
    assign b_x2 = {b_i, 1'b0};

    always_comb begin
        sum = p_i;
        unique case ({a_i[1:0], l_i})
            3'b001, 3'b010: sum = p_i + b_x1;
            3'b011:         sum = p_i + b_x2;
            3'b100:         sum = p_i - b_x2;
            3'b101, 3'b110: sum = p_i - b_x1;
            default:        sum = p_i;
        endcase
    end

    assign p_o = {{2{sum[XLEN+2]}}, sum[XLEN+2:2]};
    assign a_o = {sum[1:0], a_i[XLEN+1:2]};
    assign l_o = a_i[1];

endmodule

// File: rtl/mgt_01_booth_multiplier.sv
// -----------------------------------------------------------------------------
// mgt_01_booth_multiplier
// Iterative Booth radix-4 multiplier, one operation in flight.
//   clk_i, rst_i (async, active high), clk_en_i (stall when low)
//   kill_i                     flush of the in-flight operation
//   valid_i/ready_o            request handshake
//   operation_i, operand_a_i, operand_b_i, tag_i
//   valid_o/ready_i            result handshake
//   result_o, tag_o            selected product half and its tag
//   fu_state_o                 FREE in IDLE, BUSY otherwise
//
// Handshake: a transfer happens on a rising edge where valid, ready and
// clk_en_i are all high; the producer holds its payload until then and
// valid_o/result_o/tag_o stay stable until the result is retired.
// kill_i (with clk_en_i) beats both accept and retire.
// -----------------------------------------------------------------------------
module mgt_01_booth_multiplier
    import mgt_01_booth_multiplier_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 4,
    parameter int EARLY_ZERO = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_en_i,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  mul_ops_e         operation_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output fu_state_e        fu_state_o
);

    localparam int ITER  = iter_f(XLEN);
    localparam int CNT_W = $clog2(ITER + 1);

    mul_state_e       state_q;
    mul_ops_e         op_q;
    logic [XLEN+2:0]  p_q;
    logic [XLEN+1:0]  a_q;
    logic             l_q;
    logic [XLEN+1:0]  b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_pend_q;
    logic             valid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    logic [XLEN+2:0]    p_d;
    logic [XLEN+1:0]    a_d;
    logic               l_d;
    logic [XLEN+1:0]    a_ext;
    logic [XLEN+1:0]    b_ext;
    logic [2*XLEN+4:0]  prod;
    logic [XLEN-1:0]    result_d;
    logic               accept;
    logic               retire;
    logic               zero_fast;
    logic               unused_prod;

    mgt_01_booth_r4_step #(.XLEN(XLEN)) u_step (
        .p_i (p_q),
        .a_i (a_q),
        .l_i (l_q),
        .b_i (b_q),
        .p_o (p_d),
        .a_o (a_d),
        .l_o (l_d)
    );

    // Signedness comes entirely from operand extension: the Booth engine
    // always multiplies two signed XLEN+2-bit values.
    assign a_ext = (operation_i == MULHU_)
                 ? {2'b00, operand_a_i}
                 : {{2{operand_a_i[XLEN-1]}}, operand_a_i};
    assign b_ext = (operation_i == MULHSU_ || operation_i == MULHU_)
                 ? {2'b00, operand_b_i}
                 : {{2{operand_b_i[XLEN-1]}}, operand_b_i};

    assign zero_fast = (EARLY_ZERO != 0) &&
                       ((operand_a_i == '0) || (operand_b_i == '0));

    // Product after the final step; only the low 2*XLEN bits are meaningful.
    assign prod        = {p_d, a_d};
    assign result_d    = (op_q == MUL_) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign unused_prod = ^prod[2*XLEN+4:2*XLEN];

    assign ready_o = ((state_q == IDLE) || (state_q == DONE && ready_i)) && !kill_i;
    assign accept  = valid_i && ready_o && clk_en_i;
    assign retire  = valid_q && ready_i && clk_en_i;

    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign tag_o      = tag_q;
    assign fu_state_o = (state_q == IDLE) ? FREE : BUSY;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= MUL_;
            p_q        <= '0;
            a_q        <= '0;
            l_q        <= 1'b0;
            b_q        <= '0;
            cnt_q      <= '0;
            tag_pend_q <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            tag_q      <= '0;
        end else if (clk_en_i) begin
            if (kill_i) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                if (retire) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                // accept only in IDLE/DONE, so it never collides with a step
                if (accept) begin
                    op_q       <= operation_i;
                    p_q        <= '0;
                    a_q        <= b_ext;
                    l_q        <= 1'b0;
                    b_q        <= a_ext;
                    cnt_q      <= '0;
                    tag_pend_q <= tag_i;
                    if (zero_fast) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= '0;
                        tag_q    <= tag_i;
                    end else begin
                        state_q <= COMPUTE;
                    end
                end
                if (state_q == COMPUTE) begin
                    p_q   <= p_d;
                    a_q   <= a_d;
                    l_q   <= l_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= result_d;
                        tag_q    <= tag_pend_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_booth_multiplier.sv
module tb_mgt_01_booth_multiplier;
    import mgt_01_booth_multiplier_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        kill;
    logic        valid;
    logic        ready_in;
    mul_ops_e    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;

    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [3:0]  tag_o;
    fu_state_e   fu_state_o;

    // second instance without the zero fast path
    logic        v2;
    logic        nz_kill;
    logic        nz_clk_en;
    logic        nz_ready_in;
    logic        nz_ready_o;
    logic        nz_valid_o;
    logic [31:0] nz_result_o;
    logic [3:0]  nz_tag_o;
    fu_state_e   nz_fu_state_o;

    int total = 0;
    int bad   = 0;
    int n;
    int seen;

    always #5 clk = ~clk;

    mgt_01_booth_multiplier #(.XLEN(32), .TAG_W(4), .EARLY_ZERO(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_en_i    (clk_en),
        .kill_i      (kill),
        .valid_i     (valid),
        .ready_o     (ready_o),
        .operation_i (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .tag_i       (tag),
        .valid_o     (valid_o),
        .ready_i     (ready_in),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .fu_state_o  (fu_state_o)
    );

    mgt_01_booth_multiplier #(.XLEN(32), .TAG_W(4), .EARLY_ZERO(0)) dut_nz (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_en_i    (nz_clk_en),
        .kill_i      (nz_kill),
        .valid_i     (v2),
        .ready_o     (nz_ready_o),
        .operation_i (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .tag_i       (tag),
        .valid_o     (nz_valid_o),
        .ready_i     (nz_ready_in),
        .result_o    (nz_result_o),
        .tag_o       (nz_tag_o),
        .fu_state_o  (nz_fu_state_o)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for ready_o, then step past the accept edge.
    task automatic issue(input mul_ops_e o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] t);
        int w;
        w = 0;
        op = o; a = x; b = y; tag = t; valid = 1'b1;
        #1;
        while (!ready_o && w < 50) begin
            tick();
            w++;
        end
        chk("accept_wait", 64'(w < 50), 64'd1);
        tick();
        valid = 1'b0;
    endtask

    // Cycles from the accept edge until valid_o is seen (1 = the cycle right after).
    task automatic wait_valid(output int cnt);
        cnt = 1;
        while (!valid_o && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; clk_en = 1'b1; kill = 1'b0; valid = 1'b0; ready_in = 1'b1;
        v2 = 1'b0; nz_kill = 1'b0; nz_clk_en = 1'b1; nz_ready_in = 1'b1;
        op = MUL_; a = '0; b = '0; tag = '0;
        tick(); tick();
        chk("rst_ready",   64'(ready_o),    64'd1);
        chk("rst_valid",   64'(valid_o),    64'd0);
        chk("rst_result",  64'(result_o),   64'd0);
        chk("rst_tag",     64'(tag_o),      64'd0);
        chk("rst_fustate", 64'(fu_state_o), 64'(FREE));
        rst = 1'b0;
        tick();

        // MUL 7 * -3
        issue(MUL_, 32'd7, 32'hFFFF_FFFD, 4'd1);
        chk("mul_busy", 64'(fu_state_o), 64'(BUSY));
        chk("mul_noready", 64'(ready_o), 64'd0);
        wait_valid(n);
        chk("mul_lat", 64'(n), 64'd18);
        chk("mul_res", 64'(result_o), 64'hFFFF_FFEB);
        chk("mul_tag", 64'(tag_o), 64'd1);
        tick();

        issue(MULH_, 32'h8000_0000, 32'h8000_0000, 4'd2);
        wait_valid(n);
        chk("mulh_res", 64'(result_o), 64'h4000_0000);
        chk("mulh_tag", 64'(tag_o), 64'd2);
        tick();

        issue(MULHU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
        wait_valid(n);
        chk("mulhu_res", 64'(result_o), 64'hFFFF_FFFE);
        tick();

        issue(MULHSU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4);
        wait_valid(n);
        chk("mulhsu_res", 64'(result_o), 64'hFFFF_FFFF);
        tick();

        // -7 * 3 = -21 -> high half all ones
        issue(MULH_, 32'hFFFF_FFF9, 32'd3, 4'd5);
        wait_valid(n);
        chk("mulh_neg_res", 64'(result_o), 64'hFFFF_FFFF);
        tick();

        // 2^31 * 2 unsigned = 2^32 -> high half 1, low half 0
        issue(MULHU_, 32'h8000_0000, 32'd2, 4'd6);
        wait_valid(n);
        chk("mulhu_carry_res", 64'(result_o), 64'd1);
        tick();
        issue(MUL_, 32'h8000_0000, 32'd2, 4'd6);
        wait_valid(n);
        chk("mul_wrap_res", 64'(result_o), 64'd0);
        tick();

        // zero fast path
        issue(MUL_, 32'd123, 32'd1000, 4'd7);
        wait_valid(n);
        chk("pre_fast_res", 64'(result_o), 64'd123000);
        tick();
        issue(MULHU_, 32'd0, 32'h1234_5678, 4'd8);
        wait_valid(n);
        chk("fast_lat", 64'(n), 64'd1);
        chk("fast_res", 64'(result_o), 64'd0);
        chk("fast_tag", 64'(tag_o), 64'd8);
        tick();

        // same request on the instance without the fast path
        op = MULHU_; a = 32'd0; b = 32'h1234_5678; tag = 4'd9; v2 = 1'b1;
        #1;
        chk("nz_ready", 64'(nz_ready_o), 64'd1);
        tick();
        v2 = 1'b0;
        n = 1;
        while (!nz_valid_o && n < 100) begin
            tick();
            n++;
        end
        chk("nz_lat", 64'(n), 64'd18);
        chk("nz_res", 64'(nz_result_o), 64'd0);
        chk("nz_tag", 64'(nz_tag_o), 64'd9);
        tick();

        // backpressure then back-to-back
        ready_in = 1'b0;
        issue(MUL_, 32'd5, 32'd6, 4'd3);
        wait_valid(n);
        chk("bp_lat", 64'(n), 64'd18);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  64'(valid_o),  64'd1);
            chk("bp_res",    64'(result_o), 64'd30);
            chk("bp_tag",    64'(tag_o),    64'd3);
            chk("bp_noready", 64'(ready_o), 64'd0);
            tick();
        end
        ready_in = 1'b1;
        op = MUL_; a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFC; tag = 4'd5; valid = 1'b1;
        #1;
        chk("b2b_ready", 64'(ready_o), 64'd1);
        tick();
        valid = 1'b0;
        chk("b2b_retired", 64'(valid_o), 64'd0);
        chk("b2b_busy", 64'(fu_state_o), 64'(BUSY));
        wait_valid(n);
        chk("b2b_lat", 64'(n), 64'd18);
        chk("b2b_res", 64'(result_o), 64'd8);
        chk("b2b_tag", 64'(tag_o), 64'd5);
        tick();

        // kill mid-compute with a competing request
        issue(MUL_, 32'd9, 32'd11, 4'd6);
        for (int i = 0; i < 7; i++) tick();
        kill = 1'b1;
        op = MULHU_; a = 32'd3; b = 32'd4; tag = 4'd12; valid = 1'b1;
        #1;
        chk("kill_noready", 64'(ready_o), 64'd0);
        tick();
        kill = 1'b0; valid = 1'b0;
        chk("kill_free", 64'(fu_state_o), 64'(FREE));
        chk("kill_valid", 64'(valid_o), 64'd0);
        #1;
        chk("kill_ready", 64'(ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_o) seen++;
        end
        chk("kill_no_result", 64'(seen), 64'd0);
        issue(MUL_, 32'd9, 32'd11, 4'd7);
        wait_valid(n);
        chk("post_kill_lat", 64'(n), 64'd18);
        chk("post_kill_res", 64'(result_o), 64'd99);
        chk("post_kill_tag", 64'(tag_o), 64'd7);
        tick();

        // asynchronous reset mid-compute
        issue(MULHU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",  64'(valid_o),    64'd0);
        chk("mid_rst_ready",  64'(ready_o),    64'd1);
        chk("mid_rst_free",   64'(fu_state_o), 64'(FREE));
        chk("mid_rst_result", 64'(result_o),   64'd0);
        chk("mid_rst_tag",    64'(tag_o),      64'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_o) seen++;
        end
        chk("rst_no_result", 64'(seen), 64'd0);

        // three stalled cycles mid-operation
        issue(MUL_, 32'd7, 32'hFFFF_FFFD, 4'd10);
        n = 1;
        while (!valid_o && n < 100) begin
            if (n == 5) clk_en = 1'b0;
            if (n == 8) clk_en = 1'b1;
            tick();
            n++;
        end
        chk("stall_lat", 64'(n), 64'd21);
        chk("stall_res", 64'(result_o), 64'hFFFF_FFEB);
        chk("stall_tag", 64'(tag_o), 64'd10);
        tick();
        chk("stall_retired", 64'(valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
